// File: rtl/blob_frame_tx_if.sv
// Pixel-in / binarized-stream-out / blob-result bundle for blob_frame_tx.
// Signal names keep the block's i_/o_ naming as seen from the transmitter.
interface blob_frame_tx_if;
    // i_pix_valid qualifies i_sof/i_pix_data/i_threshold and i_blob_valid qualifies
    // i_blob_count; there is no ready on either side. o_valid has no backpressure:
    // the consumer takes o_seq on every cycle o_valid is high, and a low o_valid
    // cycle marks end of frame.
    logic       i_start;
    logic       i_sof;
    logic       i_pix_valid;
    logic [7:0] i_pix_data;
    logic [7:0] i_threshold;
    logic       i_blob_valid;
    logic [7:0] i_blob_count;
    logic       o_valid;
    logic       o_seq;
    logic       o_busy;
    logic       o_result_valid;
    logic [7:0] o_result;
    logic       o_underflow;
    logic [1:0] o_state;

    modport slave (
        input  i_start, i_sof, i_pix_valid, i_pix_data, i_threshold,
        input  i_blob_valid, i_blob_count,
        output o_valid, o_seq, o_busy, o_result_valid, o_result, o_underflow, o_state
    );

    modport master (
        output i_start, i_sof, i_pix_valid, i_pix_data, i_threshold,
        output i_blob_valid, i_blob_count,
        input  o_valid, o_seq, o_busy, o_result_valid, o_result, o_underflow, o_state
    );
endinterface

// File: rtl/blob_frame_tx.sv
// Arms on i_start, streams one gap-free binarized frame to the blob counter, then captures
// its count. Optional WAIT_RES timeout (result 8'hFF) is enabled by BLOB_TX_TIMEOUT_EN.
module blob_frame_tx #(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic           i_clk,
    input  logic           i_rst,
    blob_frame_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        STREAM   = 2'd2,
        WAIT_RES = 2'd3
    } state_t;

    localparam logic [9:0] COL_LAST = 10'(COLS - 1);
    localparam logic [8:0] ROW_LAST = 9'(ROWS - 1);

    state_t     state_q, state_d;
    logic [9:0] col_q, col_d, col_adv;
    logic [8:0] row_q, row_d, row_adv;
    logic       valid_q, valid_d;
    logic       seq_q, seq_d;
    logic       unf_q, unf_d;
    logic       res_vld_q, res_vld_d;
    logic [7:0] result_q, result_d;
    logic       pix_bin;
    logic       sof_hit;
    logic       last_pix;
`ifdef BLOB_TX_TIMEOUT_EN
    logic [11:0] tmo_q, tmo_d;
`endif

    // A missing pixel binarizes to 0 so the frame keeps its exact length.
    assign pix_bin  = bus.i_pix_valid && (bus.i_pix_data >= bus.i_threshold);
    assign sof_hit  = bus.i_sof && bus.i_pix_valid;
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Position of the pixel after the one at (row_q, col_q); folds back to 0 after the last.
    always_comb begin
        col_adv = col_q + 10'd1;
        row_adv = row_q;
        if (col_q == COL_LAST) begin
            col_adv = '0;
            row_adv = row_q + 9'd1;
        end
        if (last_pix) begin
            col_adv = '0;
            row_adv = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        valid_d   = 1'b0;
        seq_d     = 1'b0;
        unf_d     = unf_q;
        res_vld_d = 1'b0;
        result_d  = result_q;
`ifdef BLOB_TX_TIMEOUT_EN
        tmo_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = ARMED;
                    unf_d   = 1'b0;
                end
            end
            ARMED: begin
                // Counters sit at (0,0) here, so the SOF pixel advances like any other.
                if (sof_hit) begin
                    valid_d = 1'b1;
                    seq_d   = pix_bin;
                    col_d   = col_adv;
                    row_d   = row_adv;
                    state_d = last_pix ? WAIT_RES : STREAM;
                end
            end
            STREAM: begin
                valid_d = 1'b1;
                seq_d   = pix_bin;
                col_d   = col_adv;
                row_d   = row_adv;
                if (!bus.i_pix_valid) unf_d = 1'b1;
                if (last_pix) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (bus.i_blob_valid) begin
                    result_d  = bus.i_blob_count;
                    res_vld_d = 1'b1;
                    state_d   = IDLE;
                end
`ifdef BLOB_TX_TIMEOUT_EN
                // tmo_q==4094 is the 4095th waiting cycle.
                else if (tmo_q == 12'd4094) begin
                    result_d  = 8'hFF;
                    res_vld_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 12'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            seq_q     <= 1'b0;
            unf_q     <= 1'b0;
            res_vld_q <= 1'b0;
            result_q  <= 8'h00;
`ifdef BLOB_TX_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            seq_q     <= seq_d;
            unf_q     <= unf_d;
            res_vld_q <= res_vld_d;
            result_q  <= result_d;
`ifdef BLOB_TX_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign bus.o_valid        = valid_q;
    assign bus.o_seq          = seq_q;
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_result_valid = res_vld_q;
    assign bus.o_result       = result_q;
    assign bus.o_underflow    = unf_q;
    assign bus.o_state        = state_q;
endmodule

// File: tb/tb_blob_frame_tx.sv
// Bench for blob_frame_tx on a reduced 16x12 frame; a protocol model pushes expected
// {cycle, o_seq} words when pixels are driven and a negedge monitor pops them.
module tb_blob_frame_tx;
    localparam int COLS = 16;
    localparam int ROWS = 12;
    localparam int NPIX = COLS * ROWS;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_STREAM = 2'd2, S_WAIT = 2'd3;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    blob_frame_tx_if bus();

    blob_frame_tx #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    int          valid_cnt = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  m_state = S_IDLE;
    int          m_cnt = 0;
    logic        m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the protocol model accordingly.
    task automatic drive(input logic st, input logic v, input logic sof, input logic [7:0] d,
                         input logic [7:0] thr, input logic bv, input logic [7:0] bc);
        @(posedge i_clk);
        #1;
        bus.i_start      = st;
        bus.i_pix_valid  = v;
        bus.i_sof        = sof;
        bus.i_pix_data   = d;
        bus.i_threshold  = thr;
        bus.i_blob_valid = bv;
        bus.i_blob_count = bc;
        case (m_state)
            S_IDLE: if (st) begin
                m_state = S_ARMED;
                m_unf   = 1'b0;
            end
            S_ARMED: if (sof && v) begin
                exp_q.push_back({31'(cyc + 1), 1'(d >= thr)});
                m_cnt   = 1;
                m_state = (m_cnt == NPIX) ? S_WAIT : S_STREAM;
            end
            S_STREAM: begin
                exp_q.push_back({31'(cyc + 1), 1'(v && (d >= thr))});
                if (!v) m_unf = 1'b1;
                m_cnt++;
                if (m_cnt == NPIX) m_state = S_WAIT;
            end
            S_WAIT: if (bv) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    endtask

    // pat 0: all 200/thr 128; pat 1: 10/250 alternating; pat 2: random data and threshold.
    task automatic send_frame(input int pat, input int drop_at, input int glitch_at, input int stop_at);
        logic [7:0] d, thr;
        logic       v, hit;
        for (int idx = 0; idx < stop_at; idx++) begin
            case (pat)
                0:       begin d = 8'd200; thr = 8'd128; end
                1:       begin d = idx[0] ? 8'd250 : 8'd10; thr = 8'd128; end
                default: begin d = 8'($urandom_range(0, 255)); thr = 8'($urandom_range(0, 255)); end
            endcase
            v   = !(drop_at > 0 && idx >= drop_at && idx < drop_at + 5);
            hit = (idx == glitch_at);
            drive(hit, v, (idx == 0) || hit, d, thr, hit, 8'd99);
        end
    endtask

    task automatic end_frame(input logic exp_unf);
        idle(1);
        check("last_valid", 32'(bus.o_valid), 32'd1);
        check("last_state", 32'(bus.o_state), 32'(S_WAIT));
        idle(1);
        check("post_valid", 32'(bus.o_valid), 32'd0);
        check("frame_len", 32'(valid_cnt), 32'(NPIX));
        check("underflow", 32'(bus.o_underflow), 32'(exp_unf));
        check("busy_wait", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic give_result(input logic [7:0] bc, input logic [7:0] prev);
        check("res_hold", 32'(bus.o_result), 32'(prev));
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, bc);
        idle(1);
        check("res_pulse", 32'(bus.o_result_valid), 32'd1);
        check("res_value", 32'(bus.o_result), 32'(bc));
        check("res_busy", 32'(bus.o_busy), 32'd0);
        check("res_state", 32'(bus.o_state), 32'(S_IDLE));
        idle(1);
        check("res_pulse_end", 32'(bus.o_result_valid), 32'd0);
        check("res_keep", 32'(bus.o_result), 32'(bc));
    endtask

    always @(negedge i_clk) begin
        logic [31:0] e;
        if (!i_rst) begin
            if (bus.o_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("pix_extra", 32'(bus.o_valid), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("pix", {31'(cyc), bus.o_seq}, e);
                end
            end else if (exp_q.size() > 0 && exp_q[0][31:1] <= 31'(cyc)) begin
                e = exp_q.pop_front();
                check("pix_gap", 32'(bus.o_valid), 32'd1);
            end
        end
    end

    initial begin
        bus.i_start = 1'b0; bus.i_sof = 1'b0; bus.i_pix_valid = 1'b0;
        bus.i_pix_data = 8'd0; bus.i_threshold = 8'd0;
        bus.i_blob_valid = 1'b0; bus.i_blob_count = 8'd0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_seq", 32'(bus.o_seq), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_res_vld", 32'(bus.o_result_valid), 32'd0);
        check("rst_result", 32'(bus.o_result), 32'd0);
        check("rst_unf", 32'(bus.o_underflow), 32'd0);
        check("rst_state", 32'(bus.o_state), 32'(S_IDLE));
        i_rst = 1'b0;

        // Idle-state stimulus that must be ignored.
        drive(1'b0, 1'b1, 1'b1, 8'd200, 8'd128, 1'b1, 8'd55);
        idle(1);
        check("idle_blob_ign", 32'(bus.o_result_valid), 32'd0);
        check("idle_result", 32'(bus.o_result), 32'd0);

        // Frame 1: constant 200, with start/sof/blob pulses mid-stream.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd200, 8'd128, 1'b0, 8'd0);
        check("armed_state", 32'(bus.o_state), 32'(S_ARMED));
        check("armed_busy", 32'(bus.o_busy), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 8'd200, 8'd128, 1'b0, 8'd0);
        valid_cnt = 0;
        send_frame(0, -1, 70, NPIX);
        end_frame(1'b0);
        give_result(8'd17, 8'd0);

        // Frame 2: alternating 10/250.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        valid_cnt = 0;
        send_frame(1, -1, -1, NPIX);
        end_frame(1'b0);
        give_result(8'd5, 8'd17);

        // Frame 3: random pixels, 5 missing pixels at row 6.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        valid_cnt = 0;
        send_frame(2, 6 * COLS + 3, -1, NPIX);
        end_frame(m_unf);
        check("unf_set", 32'(bus.o_underflow), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        idle(1);
        check("wait_start_ign", 32'(bus.o_state), 32'(S_WAIT));
        check("wait_unf_keep", 32'(bus.o_underflow), 32'd1);
        give_result(8'd200, 8'd5);
        check("unf_sticky", 32'(bus.o_underflow), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
        idle(1);
        check("unf_clear", 32'(bus.o_underflow), 32'd0);
        check("rearm_state", 32'(bus.o_state), 32'(S_ARMED));

        // Frame 4: reset after pixel 50 is accepted.
        valid_cnt = 0;
        send_frame(2, -1, -1, 51);
        @(posedge i_clk);
        #2;
        check("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        i_rst = 1'b1;
        exp_q.delete();
        m_state = S_IDLE;
        m_unf = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_result", 32'(bus.o_result), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 30; i++)
            drive(1'b0, 1'b1, (i == 0) || (i == 10), 8'd200, 8'd128, 1'b0, 8'd0);
        idle(2);
        check("no_resume_cnt", 32'(valid_cnt), 32'd0);
        check("no_resume_state", 32'(bus.o_state), 32'(S_IDLE));

`ifdef BLOB_TX_TIMEOUT_EN
        begin
            int waited;
            drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
            valid_cnt = 0;
            send_frame(0, -1, -1, NPIX);
            idle(1);
            check("tmo_enter", 32'(bus.o_state), 32'(S_WAIT));
            waited = 0;
            while (!bus.o_result_valid && waited < 5000) begin
                idle(1);
                waited++;
            end
            check("tmo_cycles", 32'(waited), 32'd4095);
            check("tmo_result", 32'(bus.o_result), 32'hFF);
            check("tmo_state", 32'(bus.o_state), 32'(S_IDLE));
            m_state = S_IDLE;
        end
`endif

        idle(3);
        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/blob_frame_tx.md
BLOB_FRAME_TX -- requirements
Module: blob_frame_tx

Interface
REQ-001 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port i_start  input  1  one-cycle request to capture and stream one frame.
REQ-004 SHALL have port i_sof  input  1  start-of-frame marker, qualified by i_pix_valid.
REQ-005 SHALL have port i_pix_valid  input  1  grayscale pixel present this cycle.
REQ-006 SHALL have port i_pix_data  input  8  grayscale pixel value.
REQ-007 SHALL have port i_threshold  input  8  binarization threshold, sampled every accepted pixel.
REQ-008 SHALL have port i_blob_valid  input  1  result pulse from the blob counter.
REQ-009 SHALL have port i_blob_count  input  8  blob count, valid with i_blob_valid.
REQ-010 SHALL have port o_valid  output  1  frame-active strobe to the blob counter.
REQ-011 SHALL have port o_seq  output  1  binarized pixel, meaningful only while o_valid=1.
REQ-012 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port o_result_valid  output  1  one-cycle pulse when o_result updates.
REQ-014 SHALL have port o_result  output  8  last captured blob count.
REQ-015 SHALL have port o_underflow  output  1  sticky: frame contained padded pixels.

Function
REQ-016 SHALL implement states IDLE, ARMED, STREAM, WAIT_RES; 2-bit state register.
REQ-017 IDLE -> ARMED SHALL occur on i_start=1; i_start SHALL clear o_underflow; i_start in any other state SHALL be ignored.
REQ-018 ARMED -> STREAM SHALL occur on the first cycle with i_sof=1 and i_pix_valid=1; that pixel is pixel 0.
REQ-019 Frame SHALL be 640 columns x 480 rows = 307200 pixels, tracked by 10-bit column (wraps 639->0, increments row) and 9-bit row counters.
REQ-020 o_valid and o_seq SHALL be registered; latency from accepted pixel to its o_seq SHALL be exactly 1 cycle.
REQ-021 o_seq SHALL be 1 iff i_pix_data >= i_threshold (unsigned), else 0.
REQ-022 o_valid SHALL be high for exactly 307200 consecutive cycles per frame with no gaps, since the consumer treats any low cycle as end of frame.
REQ-023 In STREAM, a cycle with i_pix_valid=0 SHALL still emit one pixel with o_seq=0 and SHALL set o_underflow.
REQ-024 i_sof asserted during STREAM SHALL be ignored; counters SHALL NOT restart.
REQ-025 After pixel 307199 (row 479, col 639) is emitted, o_valid SHALL be 0 on the following cycle and state SHALL be WAIT_RES.
REQ-026 In WAIT_RES, on i_blob_valid=1 the block SHALL load o_result<=i_blob_count, pulse o_result_valid for one cycle, and return to IDLE.
REQ-027 i_blob_valid outside WAIT_RES SHALL be ignored.
REQ-028 o_result SHALL hold its value until the next capture.

Reset
REQ-029 On i_rst=1, state SHALL be IDLE; o_valid, o_seq, o_busy, o_result_valid, o_underflow SHALL be 0; o_result SHALL be 8'h00; counters SHALL be 0.
REQ-030 Reset asserted mid-STREAM SHALL drop o_valid asynchronously; no partial-frame resumption after release.

Configuration
REQ-031 Macro BLOB_TX_TIMEOUT_EN defined: WAIT_RES SHALL run a 12-bit cycle counter; after 4095 cycles without i_blob_valid it SHALL load o_result=8'hFF, pulse o_result_valid, and go to IDLE.
REQ-032 Macro BLOB_TX_TIMEOUT_EN undefined: no timeout counter; WAIT_RES SHALL wait indefinitely for i_blob_valid.

Verification
REQ-033 Reset, i_start, i_sof with continuous pixels all 200, threshold 128 -> o_valid high exactly 307200 cycles, o_seq=1 throughout, o_underflow=0.
REQ-034 Pixel stream alternating 10/250, threshold 128 -> o_seq alternates 0/1, delayed by 1 cycle from input.
REQ-035 i_pix_valid dropped for 5 cycles at row 100 -> 5 zero pixels emitted, o_valid stays high, o_underflow=1, total still 307200.
REQ-036 WAIT_RES, i_blob_valid with i_blob_count=8'd17 -> o_result=17, o_result_valid pulse of 1 cycle, o_busy=0 next cycle.
REQ-037 i_rst asserted at pixel 50000 -> o_valid=0 immediately; after release, pixels without i_start produce no o_valid.
REQ-038 With BLOB_TX_TIMEOUT_EN, no i_blob_valid for 4095 cycles -> o_result=8'hFF, o_result_valid pulse, state IDLE.
